// File: rtl/fetch_pkg.sv
// Purpose: shared constants and types for the instruction fetch stage.
// Latency: none; declarations only.
// Backpressure: none; declarations only.
package fetch_pkg;

    // Canonical bubble word: addi x0,x0,0
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
    // ebreak; acts as the halt instruction when halt detection is compiled in
    localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;

    typedef enum logic [1:0] {
        ST_RUN       = 2'b00,
        ST_HALT_PEND = 2'b01,
        ST_HALTED    = 2'b10
    } fetch_state_t;

    // IF/ID pipeline register contents
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic        valid;
    } if_id_t;

    // A bubble carries the NOP word, zeroed PCs and no valid bit
    function automatic if_id_t make_bubble(input logic [31:0] nop);
        if_id_t b;
        b.instr    = nop;
        b.pc       = 32'h0000_0000;
        b.pc_plus4 = 32'h0000_0000;
        b.valid    = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// Purpose: IF/ID pipeline register with stall, flush and bubble insertion.
// Latency: one cycle from fetch inputs to registered outputs.
// Backpressure: stall_i holds contents; flush_i beats stall_i; !load_i inserts a bubble.
module if_id_reg #(
    parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall_i,
    input  logic                   flush_i,
    input  logic                   load_i,
    input  logic [31:0]            instr_i,
    input  logic [31:0]            pc_i,
    input  logic [31:0]            pc_plus4_i,
    output fetch_pkg::if_id_t      q_o
);
    import fetch_pkg::*;

    if_id_t q_q;
    if_id_t q_d;

    // Next-state priority: reset/flush, then stall hold, then bubble when fetch is not running
    always_comb begin
        q_d = q_q;
        if (rst || flush_i) begin
            q_d = make_bubble(NOP_INSTR);
        end else if (stall_i) begin
            q_d = q_q;
        end else if (!load_i) begin
            q_d = make_bubble(NOP_INSTR);
        end else begin
            q_d.instr    = instr_i;
            q_d.pc       = pc_i;
            q_d.pc_plus4 = pc_plus4_i;
            q_d.valid    = 1'b1;
        end
    end

    // Register update; reset is folded into q_d so it is synchronous
    always_ff @(posedge clk) begin
        q_q <= q_d;
    end

    assign q_o = q_q;

endmodule

// File: rtl/fetch_stage.sv
// Purpose: PC generation, halt FSM and IF/ID register of a 5-stage RISC-V pipe (halt detect under FETCH_HALT_EN).
// Latency: word fetched at PCF in cycle N appears on InstrD in cycle N+1.
// Backpressure: StallF holds PCF, StallD holds IF/ID, FlushD inserts a bubble; PCSrcE redirects over StallF.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    input  logic [31:0] InstrF,
    output logic [31:0] PCF,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD,
    output logic        HaltF
);
    import fetch_pkg::*;

    logic [31:0]  pc_q;
    logic [31:0]  pc_d;
    logic [31:0]  pc_plus4;
    fetch_state_t state_q;
    fetch_state_t state_d;
    logic         redirect;
    logic         running;
    if_id_t       if_id;

    // Target low bits are dropped; only the word address matters
    logic [1:0]   unused_tgt_lsb;
    assign unused_tgt_lsb = PCTargetE[1:0];

    assign pc_plus4 = pc_q + 32'd4;   // natural 32-bit wrap from FFFF_FFFC to 0
    assign running  = (state_q == ST_RUN);
    // Once halted the front end ignores late redirects
    assign redirect = PCSrcE && (state_q != ST_HALTED);

    // PC next-state: reset, redirect, hold on stall or halt, else sequential
    always_comb begin
        pc_d = pc_q;
        if (rst) begin
            pc_d = {RESET_PC[31:2], 2'b00};
        end else if (redirect) begin
            pc_d = {PCTargetE[31:2], 2'b00};
        end else if (StallF || !running) begin
            pc_d = pc_q;
        end else begin
            pc_d = pc_plus4;
        end
    end

`ifdef FETCH_HALT_EN
    // Halt FSM: ebreak accepted into IF/ID arms the halt, an older branch can still cancel it
    always_comb begin
        state_d = state_q;
        if (rst) begin
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if ((InstrF == EBREAK_INSTR) && !StallD && !FlushD && !PCSrcE)
                        state_d = ST_HALT_PEND;
                end
                ST_HALT_PEND: begin
                    if (PCSrcE)
                        state_d = ST_RUN;
                    else if (StallD)
                        state_d = ST_HALT_PEND;
                    else
                        state_d = ST_HALTED;
                end
                ST_HALTED: state_d = ST_HALTED;
                default:   state_d = ST_RUN;
            endcase
        end
    end

    assign HaltF = (state_q == ST_HALTED);
`else
    // Halt detection compiled out: fetch never leaves RUN
    always_comb begin
        state_d = ST_RUN;
    end

    assign HaltF = 1'b0;
`endif

    // PC and FSM state registers; reset handled in the next-state logic
    always_ff @(posedge clk) begin
        pc_q    <= pc_d;
        state_q <= state_d;
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk        (clk),
        .rst        (rst),
        .stall_i    (StallD),
        .flush_i    (FlushD),
        .load_i     (running),
        .instr_i    (InstrF),
        .pc_i       (pc_q),
        .pc_plus4_i (pc_plus4),
        .q_o        (if_id)
    );

    assign PCF      = pc_q;
    assign InstrD   = if_id.instr;
    assign PCD      = if_id.pc;
    assign PCPlus4D = if_id.pc_plus4;
    assign ValidD   = if_id.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Purpose: directed, table-driven check of fetch_stage, with halt sequences under FETCH_HALT_EN.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: stall/flush/redirect combinations exercised through the vector table.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        StallF;
    logic        StallD;
    logic        FlushD;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic [31:0] InstrF;
    logic [31:0] PCF;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        ValidD;
    logic        HaltF;

    logic        ebreak_on;
    int          n_vec;
    int          n_miss;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] EBK = 32'h0010_0073;

    fetch_stage dut (
        .clk       (clk),
        .rst       (rst),
        .StallF    (StallF),
        .StallD    (StallD),
        .FlushD    (FlushD),
        .PCSrcE    (PCSrcE),
        .PCTargetE (PCTargetE),
        .InstrF    (InstrF),
        .PCF       (PCF),
        .InstrD    (InstrD),
        .PCD       (PCD),
        .PCPlus4D  (PCPlus4D),
        .ValidD    (ValidD),
        .HaltF     (HaltF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory model: each word equals its own address, ebreak optionally at 0x20
    always_comb begin
        InstrF = PCF;
        if (ebreak_on && (PCF == 32'h0000_0020))
            InstrF = EBK;
    end

    typedef struct {
        logic        rst;
        logic        sf;
        logic        sd;
        logic        fd;
        logic        br;
        logic [31:0] tgt;
        logic [31:0] pcf;
        logic [31:0] instr;
        logic [31:0] pcd;
        logic [31:0] p4;
        logic        vld;
        logic        halt;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic sf, input logic sd, input logic fd,
                                input logic br, input logic [31:0] tgt,
                                input logic [31:0] pcf, input logic [31:0] instr,
                                input logic [31:0] pcd, input logic [31:0] p4,
                                input logic vld, input logic halt);
        vec_t v;
        v.rst = r;  v.sf = sf;  v.sd = sd;  v.fd = fd;  v.br = br;  v.tgt = tgt;
        v.pcf = pcf; v.instr = instr; v.pcd = pcd; v.p4 = p4; v.vld = vld; v.halt = halt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Drive one vector at the falling edge, compare all outputs just after the rising edge
    task automatic step(input string tag, input vec_t v);
        @(negedge clk);
        rst       = v.rst;
        StallF    = v.sf;
        StallD    = v.sd;
        FlushD    = v.fd;
        PCSrcE    = v.br;
        PCTargetE = v.tgt;
        @(posedge clk);
        #1;
        n_vec++;
        chk({tag, ".PCF"},      PCF,             v.pcf);
        chk({tag, ".InstrD"},   InstrD,          v.instr);
        chk({tag, ".PCD"},      PCD,             v.pcd);
        chk({tag, ".PCPlus4D"}, PCPlus4D,        v.p4);
        chk({tag, ".ValidD"},   {31'd0, ValidD}, {31'd0, v.vld});
        chk({tag, ".HaltF"},    {31'd0, HaltF},  {31'd0, v.halt});
    endtask

    vec_t vt[15];

    initial begin
        n_vec     = 0;
        n_miss    = 0;
        ebreak_on = 1'b0;
        rst       = 1'b1;
        StallF    = 1'b0;
        StallD    = 1'b0;
        FlushD    = 1'b0;
        PCSrcE    = 1'b0;
        PCTargetE = 32'h0;

        //          rst sf sd fd br tgt           PCF           InstrD        PCD           PCPlus4D      V  H
        vt[0]  = mk(1, 0, 0, 0, 0, 32'h0,        32'h0,        NOP,          32'h0,        32'h0,        0, 0); // reset
        vt[1]  = mk(0, 0, 0, 0, 0, 32'h0,        32'h4,        32'h0,        32'h0,        32'h4,        1, 0); // first fetch at 0
        vt[2]  = mk(0, 0, 0, 0, 0, 32'h0,        32'h8,        32'h4,        32'h4,        32'h8,        1, 0);
        vt[3]  = mk(0, 1, 1, 0, 0, 32'h0,        32'h8,        32'h4,        32'h4,        32'h8,        1, 0); // stall 1
        vt[4]  = mk(0, 1, 1, 0, 0, 32'h0,        32'h8,        32'h4,        32'h4,        32'h8,        1, 0); // stall 2
        vt[5]  = mk(0, 0, 0, 0, 0, 32'h0,        32'hC,        32'h8,        32'h8,        32'hC,        1, 0); // release
        vt[6]  = mk(0, 0, 0, 1, 1, 32'h103,      32'h100,      NOP,          32'h0,        32'h0,        0, 0); // redirect + flush
        vt[7]  = mk(0, 0, 0, 0, 0, 32'h0,        32'h104,      32'h100,      32'h100,      32'h104,      1, 0);
        vt[8]  = mk(0, 1, 0, 0, 1, 32'h200,      32'h200,      32'h104,      32'h104,      32'h108,      1, 0); // redirect beats StallF, no self-flush
        vt[9]  = mk(0, 0, 1, 1, 0, 32'h0,        32'h204,      NOP,          32'h0,        32'h0,        0, 0); // flush beats StallD
        vt[10] = mk(0, 0, 1, 0, 0, 32'h0,        32'h208,      NOP,          32'h0,        32'h0,        0, 0); // StallD holds bubble
        vt[11] = mk(0, 0, 0, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFFC, 32'h208,      32'h208,      32'h20C,      1, 0); // low bits dropped
        vt[12] = mk(0, 0, 0, 0, 0, 32'h0,        32'h0,        32'hFFFFFFFC, 32'hFFFFFFFC, 32'h0,        1, 0); // wrap
        vt[13] = mk(1, 1, 1, 0, 0, 32'h0,        32'h0,        NOP,          32'h0,        32'h0,        0, 0); // reset mid-stall
        vt[14] = mk(0, 0, 0, 0, 0, 32'h0,        32'h4,        32'h0,        32'h0,        32'h4,        1, 0);

        for (int i = 0; i < 15; i++)
            step($sformatf("v%0d", i), vt[i]);

        // Halt sequence: land on 0x20 and fetch ebreak there
        ebreak_on = 1'b1;
        step("h0", mk(0, 0, 0, 1, 1, 32'h20, 32'h20, NOP, 32'h0, 32'h0, 0, 0));
        step("h1", mk(0, 0, 0, 0, 0, 32'h0,  32'h24, EBK, 32'h20, 32'h24, 1, 0));
`ifdef FETCH_HALT_EN
        step("h2", mk(0, 0, 0, 0, 0, 32'h0,  32'h24, NOP, 32'h0, 32'h0, 0, 1)); // HALT_PEND -> HALTED
        step("h3", mk(0, 0, 0, 0, 1, 32'h80, 32'h24, NOP, 32'h0, 32'h0, 0, 1)); // redirect ignored
        step("h4", mk(0, 0, 0, 0, 0, 32'h0,  32'h24, NOP, 32'h0, 32'h0, 0, 1)); // absorbing
        step("h5", mk(1, 0, 0, 0, 0, 32'h0,  32'h0,  NOP, 32'h0, 32'h0, 0, 0)); // reset leaves HALTED
        // Variant: older branch resolves while halt is pending
        step("p0", mk(0, 0, 0, 1, 1, 32'h20, 32'h20, NOP, 32'h0, 32'h0, 0, 0));
        step("p1", mk(0, 0, 0, 0, 0, 32'h0,  32'h24, EBK, 32'h20, 32'h24, 1, 0));
        step("p2", mk(0, 0, 0, 0, 1, 32'h80, 32'h80, NOP, 32'h0, 32'h0, 0, 0)); // back to RUN at target
        step("p3", mk(0, 0, 0, 0, 0, 32'h0,  32'h84, 32'h80, 32'h80, 32'h84, 1, 0));
`else
        step("h2", mk(0, 0, 0, 0, 0, 32'h0,  32'h28, 32'h24, 32'h24, 32'h28, 1, 0)); // ebreak is ordinary
        step("h3", mk(0, 0, 0, 0, 0, 32'h0,  32'h2C, 32'h28, 32'h28, 32'h2C, 1, 0));
`endif
        ebreak_on = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
